mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/tx_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Latency: none, this file holds declarations only.
// Backpressure: none, this file holds declarations only.
package uart_pkg;

    // Transmit FSM states. PARITY is reachable only when UART_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Byte address of the TX data register, as the core sees it.
    localparam logic [31:0] UART_ADDR_DEFAULT = 32'h0000_0100;

    // Even parity bit: set when the byte has an odd number of ones.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO holding bytes waiting for the serialiser.
// Latency: a push is visible on dout/empty after the push edge.
// Backpressure: push is refused when full unless a pop happens on the same edge.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop frees the head slot on the same edge, so a full FIFO may still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: core stores to UART_ADDR queue a byte that is sent 8N1 (8E1 with UART_PARITY_EN).
// Latency: store accepted at edge N into an idle, empty block drives the start bit after edge N+1.
// Backpressure: none toward the core; stores arriving while the FIFO is full (and not popping) are dropped and counted.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] UART_ADDR    = UART_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  drop_cnt
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    uart_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_d;
    logic          pop;
    logic          accept;
    logic          drop;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          unused_wdata_hi;
`ifdef UART_PARITY_EN
    logic          par_q, par_d;
`endif

    // Only the low byte of the store is transmitted.
    assign unused_wdata_hi = ^WriteData[31:8];

    assign accept = MemWrite && (DataAdr == UART_ADDR);
    assign drop   = accept && fifo_full && !pop;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Busy covers both an in-flight frame and bytes still queued.
    assign busy = (state_q != IDLE) || !fifo_empty;

    // Next-state logic; tx_d is the line level for the state being entered, so tx is a pure register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    cnt_d   = RELOAD;
                    shreg_d = fifo_dout;
`ifdef UART_PARITY_EN
                    par_d   = even_parity(fifo_dout);
`endif
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = RELOAD;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    state_d = STOP;
                    cnt_d   = RELOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        // Back-to-back frame: pop on the edge that ends this stop bit.
                        pop     = 1'b1;
                        state_d = START;
                        cnt_d   = RELOAD;
                        shreg_d = fifo_dout;
`ifdef UART_PARITY_EN
                        par_d   = even_parity(fifo_dout);
`endif
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = 3'd0;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // FSM, counters, shift register and line register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx      <= 1'b1;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx      <= tx_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Saturating count of stores lost to a full FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= 8'h00;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with default parameters.
// Latency: checks start bit one edge after the accepting edge, frame length and back-to-back framing.
// Backpressure: exercises FIFO overflow drops and the full-with-pop acceptance case.
module tb_mmio_uart_tx;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int FL = 11 * CPB;
`else
    localparam int FL = 10 * CPB;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
    );

    // Expected per-cycle line level for one frame: start 0, data LSB first, [parity], stop 1.
    function automatic logic [63:0] wave(input logic [7:0] b);
        logic [10:0] fr;
        logic [63:0] w;
        int          nb;
`ifdef UART_PARITY_EN
        fr = {1'b1, ^b, b, 1'b0};
        nb = 11;
`else
        fr = {1'b0, 1'b1, b, 1'b0};
        nb = 10;
`endif
        w = '0;
        for (int k = 0; k < nb * CPB; k++) begin
            w[k] = fr[k / CPB];
        end
        return w;
    endfunction

    // Expected line level for n back-to-back frames; byte f sits in bytes[8f +: 8].
    function automatic logic [255:0] stream(input logic [39:0] bytes, input int n);
        logic [255:0] s;
        logic [63:0]  w;
        s = '0;
        for (int f = 0; f < n; f++) begin
            w = wave(bytes[8*f +: 8]);
            for (int k = 0; k < FL; k++) begin
                s[f*FL + k] = w[k];
            end
        end
        return s;
    endfunction

    function automatic logic [255:0] ones(input int n);
        logic [255:0] m;
        m = '0;
        for (int k = 0; k < n; k++) begin
            m[k] = 1'b1;
        end
        return m;
    endfunction

    // Samples tx and busy on the next n falling edges.
    task automatic capture(input int n, output logic [255:0] txw, output logic [255:0] bw);
        txw = '0;
        bw  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            txw[i] = tx;
            bw[i]  = busy;
        end
    endtask

    // One-cycle store; caller is positioned at a falling edge, returns at the next one.
    task automatic store(input logic [31:0] a, input logic [7:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = {24'hABCDEF, d};
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic test_reset();
        logic [255:0] tw, bw;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL reset_drop got=%h exp=00", drop_cnt); end
        reset = 1'b1;
        capture(10, tw, bw);
        checks++; if (tw !== ones(10)) begin failures++; $display("FAIL release_tx got=%h exp=%h", tw, ones(10)); end
        checks++; if (bw !== '0) begin failures++; $display("FAIL release_busy got=%h exp=0", bw); end
    endtask

    task automatic test_single_frame();
        logic [255:0] tw, bw, exp;
        store(32'h100, 8'h55);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_pre_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_pre_busy got=%b exp=1", busy); end
        capture(FL, tw, bw);
        exp = stream({32'h0, 8'h55}, 1);
        checks++; if (tw !== exp) begin failures++; $display("FAIL single_wave got=%h exp=%h", tw, exp); end
        checks++; if (bw !== ones(FL)) begin failures++; $display("FAIL single_busy got=%h exp=%h", bw, ones(FL)); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_idle_tx got=%b exp=1", tx); end
    endtask

    task automatic test_wrong_addr();
        logic [255:0] tw, bw;
        store(32'h104, 8'hA5);
        // Right address but no strobe must also be ignored.
        DataAdr   = 32'h100;
        WriteData = 32'h0000_00C3;
        capture(2 * FL, tw, bw);
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        checks++; if (tw !== ones(2 * FL)) begin failures++; $display("FAIL wrongaddr_tx got=%h exp=%h", tw, ones(2 * FL)); end
        checks++; if (bw !== '0) begin failures++; $display("FAIL wrongaddr_busy got=%h exp=0", bw); end
        checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL wrongaddr_full got=%b exp=0", fifo_full); end
    endtask

    task automatic test_overflow();
        logic [255:0] tw, bw, exp;
        for (int i = 1; i <= 6; i++) begin
            MemWrite  = 1'b1;
            DataAdr   = 32'h100;
            WriteData = 32'(i);
            @(negedge clk);
        end
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", fifo_full); end
        checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL ovf_drop got=%0d exp=1", drop_cnt); end
        // Frame 0x01 started on the second store edge; five of its cycles have elapsed.
        capture(5 * FL - 5, tw, bw);
        exp = stream({8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 5) >> 5;
        checks++; if (tw !== exp) begin failures++; $display("FAIL ovf_stream got=%h exp=%h", tw, exp); end
        checks++; if (bw !== ones(5 * FL - 5)) begin failures++; $display("FAIL ovf_busy got=%h exp=%h", bw, ones(5 * FL - 5)); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_end_busy got=%b exp=0", busy); end
        checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL ovf_end_drop got=%0d exp=1", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] tw, bw, exp;
        store(32'h100, 8'h3C);
        store(32'h100, 8'h11);
        // Now one cycle into the start bit; five more lands in data bit 0 (a zero).
        repeat (5) @(negedge clk);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_pre_tx got=%b exp=0", tx); end
        #2 reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_rst_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL mid_rst_drop got=%h exp=00", drop_cnt); end
        checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL mid_rst_full got=%b exp=0", fifo_full); end
        @(negedge clk);
        reset = 1'b1;
        capture(2 * FL, tw, bw);
        checks++; if (tw !== ones(2 * FL)) begin failures++; $display("FAIL mid_release_tx got=%h exp=%h", tw, ones(2 * FL)); end
        checks++; if (bw !== '0) begin failures++; $display("FAIL mid_release_busy got=%h exp=0", bw); end
        store(32'h100, 8'h7E);
        capture(FL, tw, bw);
        exp = stream({32'h0, 8'h7E}, 1);
        checks++; if (tw !== exp) begin failures++; $display("FAIL mid_7e_wave got=%h exp=%h", tw, exp); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_7e_busy got=%b exp=0", busy); end
    endtask

    task automatic test_pop_edge_store();
        logic [255:0] tw, bw, exp;
        logic [7:0]   fill [5];
        fill = '{8'hA0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        foreach (fill[i]) begin
            MemWrite  = 1'b1;
            DataAdr   = 32'h100;
            WriteData = {24'h0, fill[i]};
            @(negedge clk);
        end
        MemWrite  = 1'b0;
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL popedge_fill got=%b exp=1", fifo_full); end
        // Frame 0xA0 began on the second store edge; line the next store up with its STOP->START edge.
        repeat (FL - 4) @(negedge clk);
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL popedge_prefull got=%b exp=1", fifo_full); end
        store(32'h100, 8'hC5);
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL popedge_drop got=%h exp=00", drop_cnt); end
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL popedge_full got=%b exp=1", fifo_full); end
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL popedge_start got=%b exp=0", tx); end
        capture(5 * FL - 1, tw, bw);
        exp = stream({8'hC5, 8'hB4, 8'hB3, 8'hB2, 8'hB1}, 5) >> 1;
        checks++; if (tw !== exp) begin failures++; $display("FAIL popedge_stream got=%h exp=%h", tw, exp); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL popedge_end_busy got=%b exp=0", busy); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [255:0] tw, bw, exp;
        store(32'h100, 8'h07);
        capture(FL, tw, bw);
        exp = stream({32'h0, 8'h07}, 1);
        checks++; if (tw !== exp) begin failures++; $display("FAIL par07_wave got=%h exp=%h", tw, exp); end
        checks++; if (tw[9*CPB + 1] !== 1'b1) begin failures++; $display("FAIL par07_bit got=%b exp=1", tw[9*CPB + 1]); end
        @(negedge clk);
        store(32'h100, 8'h03);
        capture(FL, tw, bw);
        checks++; if (tw[9*CPB + 1] !== 1'b0) begin failures++; $display("FAIL par03_bit got=%b exp=0", tw[9*CPB + 1]); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_wrong_addr();
        test_overflow();
        test_reset_mid();
        test_pop_edge_store();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
